// File: rtl/ex_div_if.sv
// ex_div_if: execute-stage <-> divide unit handshake bundle.
//   master (execute stage) drives: start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i
//   slave  (divide unit)   drives: busy_o, hold_o, ready_o, result_o, rd_addr_o, rd_wen_o
// Signal suffixes are written from the divide unit's point of view.
interface ex_div_if #(
    parameter int unsigned DATA_W = 32
);
    logic              start_i;
    logic [2:0]        op_i;
    logic [DATA_W-1:0] dividend_i;
    logic [DATA_W-1:0] divisor_i;
    logic [4:0]        rd_addr_i;
    logic              flush_i;
    logic              busy_o;
    logic              hold_o;
    logic              ready_o;
    logic [DATA_W-1:0] result_o;
    logic [4:0]        rd_addr_o;
    logic              rd_wen_o;

    modport master (
        output start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
        input  busy_o, hold_o, ready_o, result_o, rd_addr_o, rd_wen_o
    );

    modport slave (
        input  start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
        output busy_o, hold_o, ready_o, result_o, rd_addr_o, rd_wen_o
    );
endinterface

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: multi-cycle RV32M DIV/DIVU/REM/REMU unit beside the execute stage.
// A radix-2 restoring divider runs on operand magnitudes, one quotient bit per cycle,
// and fixes up signs at the end. Divide-by-zero and signed overflow bypass the loop.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - ex_div_if.slave: launch/operands/flush in, busy/hold/ready/result/writeback out
module ex_div_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input logic     clk,
    input logic     rst_n,
    ex_div_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StCalc, StEnd} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quot_q, quot_d;
    logic [DATA_W-1:0] dsr_q, dsr_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              neg_quot_q, neg_quot_d;
    logic              neg_rem_q, neg_rem_d;
    logic              is_rem_q, is_rem_d;
    logic [4:0]        rd_q, rd_d;

    // Launch decode
    logic              launch;
    logic              op_signed;
    logic              op_rem;
    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic              div_zero, overflow, special;
    logic [DATA_W-1:0] special_res;

    assign launch    = (state_q == StIdle) && bus.start_i && bus.op_i[2] && !bus.flush_i;
    assign op_signed = !bus.op_i[0];
    assign op_rem    = bus.op_i[1];
    assign a_neg     = op_signed && bus.dividend_i[DATA_W-1];
    assign b_neg     = op_signed && bus.divisor_i[DATA_W-1];
    assign a_mag     = a_neg ? -bus.dividend_i : bus.dividend_i;
    assign b_mag     = b_neg ? -bus.divisor_i : bus.divisor_i;
    assign div_zero  = (bus.divisor_i == '0);
    assign overflow  = op_signed && (bus.dividend_i == {1'b1, {(DATA_W-1){1'b0}}})
                       && (bus.divisor_i == '1);
    assign special   = div_zero || overflow;

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = op_rem ? bus.dividend_i : '1;
        end else if (overflow) begin
            special_res = op_rem ? '0 : {1'b1, {(DATA_W-1){1'b0}}};
        end
    end

    // One restoring step: shift {rem,quot} left, trial-subtract, keep or restore.
    logic [DATA_W:0]   rem_sh, diff;
    logic [DATA_W-1:0] step_rem, step_quot;
    logic [DATA_W-1:0] fin_quot, fin_rem, calc_res;
    logic              last_iter;

    assign rem_sh    = {rem_q, quot_q[DATA_W-1]};
    assign diff      = rem_sh - {1'b0, dsr_q};
    assign step_rem  = diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
    assign step_quot = {quot_q[DATA_W-2:0], !diff[DATA_W]};
    assign fin_quot  = neg_quot_q ? -step_quot : step_quot;
    assign fin_rem   = neg_rem_q ? -step_rem : step_rem;
    assign calc_res  = is_rem_q ? fin_rem : fin_quot;
    assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (launch) begin
                    state_d = special ? StEnd : StCalc;
                end
            end
            StCalc: begin
                if (bus.flush_i) begin
                    state_d = StIdle;
                end else if (last_iter) begin
                    state_d = StEnd;
                end
            end
            StEnd:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        dsr_d      = dsr_q;
        result_d   = result_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        is_rem_d   = is_rem_q;
        rd_d       = rd_q;
        if (launch) begin
            cnt_d      = '0;
            rem_d      = '0;
            quot_d     = a_mag;
            dsr_d      = b_mag;
            neg_quot_d = a_neg ^ b_neg;
            neg_rem_d  = a_neg;
            is_rem_d   = op_rem;
            rd_d       = bus.rd_addr_i;
            if (special) begin
                result_d = special_res;
            end
        end else if (state_q == StCalc && !bus.flush_i) begin
            cnt_d  = cnt_q + 1'b1;
            rem_d  = step_rem;
            quot_d = step_quot;
            // Result is loaded on the edge into END so it never changes mid-operation.
            if (last_iter) begin
                result_d = calc_res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            dsr_q      <= '0;
            result_q   <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            is_rem_q   <= 1'b0;
            rd_q       <= '0;
        end else begin
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            dsr_q      <= dsr_d;
            result_q   <= result_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            is_rem_q   <= is_rem_d;
            rd_q       <= rd_d;
        end
    end

    // Outputs
    always_comb begin
        bus.busy_o    = (state_q != StIdle);
        // Stall starts in the launch cycle itself, before busy rises.
        bus.hold_o    = (state_q != StIdle) || launch;
        bus.ready_o   = (state_q == StEnd) && !bus.flush_i;
        bus.rd_wen_o  = (state_q == StEnd) && !bus.flush_i;
        bus.result_o  = result_q;
        bus.rd_addr_o = rd_q;
    end

endmodule

// File: tb/tb_ex_div_ctrl.sv
module tb_ex_div_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    ex_div_if #(.DATA_W(32)) bus ();

    ex_div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    // Reference: RISC-V M-extension rules with plain arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int          sa, sb;
        logic [31:0] q, r;
        bit          sgn;
        sgn = !op[0];
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
        end else if (sgn) begin
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Drives one launch and watches for ready with a bounded cycle budget.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output bit seen, output int lat,
                          output logic [31:0] res, output logic [4:0] rdo,
                          output logic wen, output logic hold_launch);
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.op_i       = op;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        bus.rd_addr_i  = rd;
        #1 hold_launch = bus.hold_o;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        seen = 0;
        lat  = 0;
        res  = '0;
        rdo  = '0;
        wen  = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (bus.ready_o) begin
                seen = 1;
                lat  = c;
                res  = bus.result_o;
                rdo  = bus.rd_addr_o;
                wen  = bus.rd_wen_o;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy_o, bus.hold_o, bus.ready_o, bus.rd_wen_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.busy_o, bus.hold_o, bus.ready_o, bus.rd_wen_o});
        end
        n_checks++;
        if (bus.result_o !== 32'h0 || bus.rd_addr_o !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_data: got result=%h rd=%0d want 0/0",
                     bus.result_o, bus.rd_addr_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_op(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd);
        bit          seen;
        int          lat;
        logic [31:0] res;
        logic [4:0]  rdo;
        logic        wen, hl;
        run_op(op, a, b, rd, seen, lat, res, rdo, wen, hl);
        n_checks++;
        if (!seen || lat != model_lat(op, a, b) || hl !== 1'b1 || wen !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timing: got seen=%0d lat=%0d hold=%b wen=%b want 1/%0d/1/1",
                     name, seen, lat, hl, wen, model_lat(op, a, b));
        end
        n_checks++;
        if (res !== model(op, a, b) || rdo !== rd) begin
            n_fail++;
            $display("FAIL %s_result: got %h rd=%0d want %h rd=%0d", name, res, rdo,
                     model(op, a, b), rd);
        end
    endtask

    task automatic test_divu_basic();
        check_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd5);
        @(negedge clk);
        n_checks++;
        if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL divu_after_end: got busy=%b ready=%b want 0/0",
                     bus.busy_o, bus.ready_o);
        end
    endtask

    task automatic test_signed();
        check_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd1);
        check_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd2);
        check_op("remu_m7_2", OP_REMU, 32'hFFFF_FFF9, 32'd2, 5'd3);
        check_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd4);
    endtask

    task automatic test_div_zero();
        check_op("div_zero", OP_DIV, 32'd1234, 32'd0, 5'd6);
        check_op("remu_zero", OP_REMU, 32'd1234, 32'd0, 5'd7);
    endtask

    task automatic test_overflow();
        check_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        check_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    endtask

    task automatic test_flush();
        int ready_cnt;
        ready_cnt = 0;
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = OP_DIVU;
        bus.dividend_i = 32'd1000; bus.divisor_i = 32'd3; bus.rd_addr_i = 5'd10;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (10) @(negedge clk);
        bus.flush_i = 1'b1;
        #1 if (bus.ready_o) ready_cnt++;
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy_o !== 1'b0 || bus.hold_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drop: got busy=%b hold=%b want 0/0", bus.busy_o, bus.hold_o);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.ready_o) ready_cnt++;
        end
        n_checks++;
        if (ready_cnt != 0) begin
            n_fail++;
            $display("FAIL flush_no_ready: got %0d ready pulses want 0", ready_cnt);
        end
        check_op("after_flush", OP_DIVU, 32'd9, 32'd3, 5'd11);
    endtask

    task automatic test_reset_mid();
        int ready_cnt;
        ready_cnt = 0;
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = OP_DIV;
        bus.dividend_i = 32'd77; bus.divisor_i = 32'd5; bus.rd_addr_i = 5'd12;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy_o, bus.hold_o, bus.ready_o, bus.rd_wen_o} !== 4'b0
            || bus.result_o !== 32'h0 || bus.rd_addr_o !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got flags=%b result=%h rd=%0d want 0",
                     {bus.busy_o, bus.hold_o, bus.ready_o, bus.rd_wen_o},
                     bus.result_o, bus.rd_addr_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.ready_o || bus.busy_o) ready_cnt++;
        end
        n_checks++;
        if (ready_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: got %0d active cycles want 0", ready_cnt);
        end
    endtask

    task automatic test_ignored();
        int          ready_cnt;
        int          lat;
        logic [31:0] res;
        ready_cnt = 0;
        // start with flush in IDLE
        @(negedge clk);
        bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.op_i = OP_DIVU;
        bus.dividend_i = 32'd50; bus.divisor_i = 32'd5; bus.rd_addr_i = 5'd13;
        #1;
        n_checks++;
        if (bus.hold_o !== 1'b0) begin
            n_fail++;
            $display("FAIL start_flush_hold: got %b want 0", bus.hold_o);
        end
        @(posedge clk);
        #1 bus.start_i = 1'b0; bus.flush_i = 1'b0;
        // start with a non-divide funct3
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 3'b000;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.ready_o || bus.busy_o) ready_cnt++;
        end
        n_checks++;
        if (ready_cnt != 0) begin
            n_fail++;
            $display("FAIL ignored_idle: got %0d active cycles want 0", ready_cnt);
        end
        // start while busy must not disturb the running operation
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = OP_DIVU;
        bus.dividend_i = 32'd200; bus.divisor_i = 32'd9; bus.rd_addr_i = 5'd14;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        lat = 0;
        res = '0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 5) begin
                bus.start_i = 1'b1; bus.op_i = OP_REMU;
                bus.dividend_i = 32'd7; bus.divisor_i = 32'd2; bus.rd_addr_i = 5'd15;
            end else begin
                bus.start_i = 1'b0;
            end
            if (bus.ready_o) begin
                lat = c;
                res = bus.result_o;
            end
        end
        bus.start_i = 1'b0;
        n_checks++;
        if (lat != 33 || res !== model(OP_DIVU, 32'd200, 32'd9)) begin
            n_fail++;
            $display("FAIL start_busy: got lat=%0d res=%h want 33/%h", lat, res,
                     model(OP_DIVU, 32'd200, 32'd9));
        end
    endtask

    task automatic test_back_to_back();
        bit          seen;
        int          lat;
        logic [31:0] res;
        logic [4:0]  rdo;
        logic        wen, hl;
        run_op(OP_DIV, 32'd1234, 32'd0, 5'd16, seen, lat, res, rdo, wen, hl);
        // Next run_op launches in the IDLE cycle right after END.
        run_op(OP_REM, 32'hFFFF_FF00, 32'd7, 5'd17, seen, lat, res, rdo, wen, hl);
        n_checks++;
        if (!seen || lat != 33 || hl !== 1'b1 || res !== model(OP_REM, 32'hFFFF_FF00, 32'd7)
            || rdo !== 5'd17) begin
            n_fail++;
            $display("FAIL back_to_back: got seen=%0d lat=%0d hold=%b res=%h rd=%0d want 1/33/1/%h/17",
                     seen, lat, hl, res, rdo, model(OP_REM, 32'hFFFF_FF00, 32'd7));
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [4:0]  rd;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(4, 7));
            a  = $urandom;
            b  = $urandom;
            rd = 5'($urandom);
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 100);
                default: ;
            endcase
            check_op("random", op, a, b, rd);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.start_i    = 1'b0;
        bus.op_i       = 3'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        bus.rd_addr_i  = '0;
        bus.flush_i    = 1'b0;
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_zero();
        test_overflow();
        test_flush();
        test_reset_mid();
        test_ignored();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
